// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the decoded key pair.
// master: the scanner (drives columns, reads rows, presents the key).
// slave:  the keypad/consumer side (drives rows, reads columns and key).
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        input  row_in,
        output col_out,
        output key_valid,
        output key_code
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_valid,
        input  key_code
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// synchronises and debounces the row returns and presents one decoded key
// as a level-valid key_code/key_valid pair.
// Optional build macro KEYPAD_AUTOREPEAT_EN: while a key (0-9, A-D) is held,
// key_valid drops for one cycle after REPEAT_DELAY hold cycles and then
// every REPEAT_PERIOD cycles.
module keypad_scanner #(
    parameter int COL_DWELL       = 4,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master kp
);
    localparam int DWELL_W = $clog2(COL_DWELL + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(COL_DWELL - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(COL_DWELL);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT         = HOLD_W'(HOLD_MAX);
`endif

    typedef enum logic [1:0] {
        ST_SCAN        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    // One-low mask for a line index (column drive and expected row pattern).
    function automatic logic [3:0] low_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    low_mask = 4'b1110;
            2'd1:    low_mask = 4'b1101;
            2'd2:    low_mask = 4'b1011;
            2'd3:    low_mask = 4'b0111;
            default: low_mask = 4'b1111;
        endcase
    endfunction

    // True when exactly one row is pulled low.
    function automatic logic single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    // Index of the low row; only meaningful when single_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] rows);
        case (rows)
            4'b1110: low_index = 2'd0;
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    // Keypad legend: * encodes as E, # as F.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'hE;
            4'b11_01: key_map = 4'h0;
            4'b11_10: key_map = 4'hF;
            4'b11_11: key_map = 4'hD;
            default:  key_map = 4'h0;
        endcase
    endfunction

    logic [3:0]         row_meta_r, row_sync_r;
    state_t             state_r, state_s;
    logic [1:0]         col_r, col_s;
    logic [3:0]         col_out_r;
    logic [DWELL_W-1:0] dwell_r, dwell_s;
    logic [DEB_W-1:0]   deb_r, deb_s, deb_inc_s;
    logic [1:0]         row_idx_r, row_idx_s;
    logic [3:0]         latched_s;
    logic               key_valid_r, key_valid_s;
    logic [3:0]         key_code_r, key_code_s;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [HOLD_W-1:0]  hold_r, hold_s;
    logic               rep_r, rep_s;
`endif

    // Two-flop synchroniser for the asynchronous row returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= kp.row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Next-state logic: column scan, press/release debounce, key presentation
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        dwell_s     = dwell_r;
        deb_s       = deb_r;
        row_idx_s   = row_idx_r;
        key_valid_s = key_valid_r;
        key_code_s  = key_code_r;
        latched_s   = low_mask(row_idx_r);
        deb_inc_s   = (deb_r == DEB_MAX) ? deb_r : deb_r + DEB_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
        hold_s      = '0;
        rep_s       = 1'b0;
`endif
        case (state_r)
            ST_SCAN: begin
                if (dwell_r == DWELL_LAST) begin
                    dwell_s = '0;
                    if (single_low(row_sync_r)) begin
                        state_s   = ST_DEB_PRESS;
                        row_idx_s = low_index(row_sync_r);
                        deb_s     = '0;
                    end else begin
                        col_s = col_r + 2'd1;
                    end
                end else begin
                    dwell_s = (dwell_r == DWELL_MAX) ? dwell_r : dwell_r + DWELL_W'(1);
                end
            end
            ST_DEB_PRESS: begin
                if (row_sync_r == latched_s) begin
                    if (deb_r == DEB_LAST) begin
                        state_s     = ST_HELD;
                        deb_s       = '0;
                        key_valid_s = 1'b1;
                        key_code_s  = key_map(row_idx_r, col_r);
                    end else begin
                        deb_s = deb_inc_s;
                    end
                end else begin
                    state_s = ST_SCAN;
                    col_s   = col_r + 2'd1;
                    dwell_s = '0;
                    deb_s   = '0;
                end
            end
            ST_HELD: begin
                if (row_sync_r != latched_s) begin
                    // The first all-idle sample already counts toward release.
                    state_s     = ST_DEB_RELEASE;
                    key_valid_s = 1'b1;
                    deb_s       = (row_sync_r == 4'hF) ? DEB_W'(1) : '0;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_s = rep_r;
                    if ((key_code_r <= 4'hD) &&
                        (hold_r == (rep_r ? HOLD_PERIOD_LAST : HOLD_DELAY_LAST))) begin
                        key_valid_s = 1'b0;
                        hold_s      = '0;
                        rep_s       = 1'b1;
                    end else begin
                        key_valid_s = 1'b1;
                        hold_s      = (hold_r == HOLD_SAT) ? hold_r : hold_r + HOLD_W'(1);
                    end
`else
                    key_valid_s = 1'b1;
`endif
                end
            end
            ST_DEB_RELEASE: begin
                if (row_sync_r == 4'hF) begin
                    if (deb_r == DEB_LAST) begin
                        state_s     = ST_SCAN;
                        key_valid_s = 1'b0;
                        col_s       = col_r + 2'd1;
                        dwell_s     = '0;
                        deb_s       = '0;
                    end else begin
                        deb_s = deb_inc_s;
                    end
                end else if (row_sync_r == latched_s) begin
                    state_s     = ST_HELD;
                    key_valid_s = 1'b1;
                    deb_s       = '0;
                end else begin
                    deb_s = '0;
                end
            end
            default: begin
                state_s     = ST_SCAN;
                col_s       = 2'd0;
                dwell_s     = '0;
                deb_s       = '0;
                key_valid_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_SCAN;
            col_r       <= 2'd0;
            col_out_r   <= 4'b1110;
            dwell_r     <= '0;
            deb_r       <= '0;
            row_idx_r   <= 2'd0;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_r      <= '0;
            rep_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            col_out_r   <= low_mask(col_s);
            dwell_r     <= dwell_s;
            deb_r       <= deb_s;
            row_idx_r   <= row_idx_s;
            key_valid_r <= key_valid_s;
            key_code_r  <= key_code_s;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_r      <= hold_s;
            rep_r       <= rep_s;
`endif
        end
    end

    assign kp.col_out   = col_out_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_code  = key_code_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: passive keypad matrix model driven by the scanner's
// columns, a cycle-level behavioural model of the scanner, and directed
// press/bounce/ghost/reset scenarios with hand-computed checks.
module tb_keypad_scanner;
    localparam int DWELL = 4;
    localparam int DEB   = 20;
    localparam int RDLY  = 50;
    localparam int RPER  = 10;
    localparam int LAT   = 4 * DWELL + 2 + DEB;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_DROPS_7 = 5;
`else
    localparam int EXP_DROPS_7 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] pressed = '0;  // index row*4+col
    int n_vec = 0;
    int n_err = 0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .COL_DWELL(DWELL), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp(kp.master)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a pressed key sits on a driven column.
    logic [3:0] rows_v;
    always_comb begin
        rows_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_out[c]) rows_v[r] = 1'b0;
        kp.row_in = rows_v;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rows seen by the scanner at each rising edge.
    logic [3:0] row_cap = 4'hF;
    always @(posedge clk) row_cap <= kp.row_in;

    // Behavioural model state.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};
    localparam int M_SCAN = 0, M_CONFIRM = 1, M_HOLD = 2, M_RELEASE = 3;
    int m_mode, m_col, m_tick, m_row, m_run, m_hold, m_lows, m_lowrow;
    bit m_rep;
    logic [3:0] m_s1, m_s2, m_seen, m_pat, m_expcol, m_code;
    logic m_valid, prev_valid;
    int n_rise = 0;
    int n_fall = 0;

    initial begin : model_proc
        m_mode = M_SCAN; m_col = 0; m_tick = 0; m_row = 0; m_run = 0;
        m_hold = 0; m_rep = 0; m_s1 = 4'hF; m_s2 = 4'hF;
        m_valid = 1'b0; m_code = 4'h0; prev_valid = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (rst) begin
                m_mode = M_SCAN; m_col = 0; m_tick = 0; m_run = 0;
                m_hold = 0; m_rep = 0; m_s1 = 4'hF; m_s2 = 4'hF;
                m_valid = 1'b0; m_code = 4'h0;
            end else begin
                m_seen = m_s2;
                m_s2 = m_s1;
                m_s1 = row_cap;
                m_lows = 0; m_lowrow = 0;
                for (int r = 0; r < 4; r++)
                    if (!m_seen[r]) begin m_lows++; m_lowrow = r; end
                m_pat = 4'hF;
                m_pat[m_row] = 1'b0;
                case (m_mode)
                    M_SCAN: begin
                        if (m_tick == DWELL - 1) begin
                            m_tick = 0;
                            if (m_lows == 1) begin
                                m_mode = M_CONFIRM; m_row = m_lowrow; m_run = 0;
                            end else m_col = (m_col + 1) % 4;
                        end else m_tick++;
                    end
                    M_CONFIRM: begin
                        if (m_seen == m_pat) begin
                            m_run++;
                            if (m_run == DEB) begin
                                m_valid = 1'b1; m_code = keymap[m_row*4+m_col];
                                m_mode = M_HOLD; m_hold = 0; m_rep = 0;
                            end
                        end else begin
                            m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_tick = 0;
                        end
                    end
                    M_HOLD: begin
                        if (m_seen != m_pat) begin
                            m_mode = M_RELEASE; m_valid = 1'b1;
                            m_run = (m_seen == 4'hF) ? 1 : 0;
                        end else begin
                            m_valid = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (m_code <= 4'hD) begin
                                m_hold++;
                                if (m_hold == (m_rep ? RPER : RDLY)) begin
                                    m_valid = 1'b0; m_hold = 0; m_rep = 1;
                                end
                            end
`endif
                        end
                    end
                    default: begin
                        if (m_seen == 4'hF) begin
                            m_run++;
                            if (m_run == DEB) begin
                                m_valid = 1'b0; m_mode = M_SCAN;
                                m_col = (m_col + 1) % 4; m_tick = 0;
                            end
                        end else if (m_seen == m_pat) begin
                            m_mode = M_HOLD; m_hold = 0; m_rep = 0; m_valid = 1'b1;
                        end else m_run = 0;
                    end
                endcase
            end
            m_expcol = 4'hF;
            m_expcol[m_col] = 1'b0;
            chk("model_col_out", 32'(kp.col_out), 32'(m_expcol));
            chk("model_key_valid", 32'(kp.key_valid), 32'(m_valid));
            chk("model_key_code", 32'(kp.key_code), 32'(m_code));
            if (kp.key_valid && !prev_valid) n_rise++;
            if (!kp.key_valid && prev_valid) n_fall++;
            prev_valid = kp.key_valid;
        end
    end

    // Wait (bounded) on negedges for key_valid to reach lvl; n = cycles waited.
    task automatic wait_level(input logic lvl, input int max_cyc, input string name, output int n);
        n = 0;
        while (kp.key_valid !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(kp.key_valid), 32'(lvl));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n, r0, f0, drops;
        repeat (3) @(negedge clk);
        chk("reset_col_out", 32'(kp.col_out), 32'h0000_000E);
        chk("reset_key_valid", 32'(kp.key_valid), 32'h0);
        chk("reset_key_code", 32'(kp.key_code), 32'h0);
        rst = 1'b0;

        // Idle scan order: each column for DWELL cycles.
        repeat (4) @(negedge clk); chk("scan_col1", 32'(kp.col_out), 32'h0000_000D);
        repeat (4) @(negedge clk); chk("scan_col2", 32'(kp.col_out), 32'h0000_000B);
        repeat (4) @(negedge clk); chk("scan_col3", 32'(kp.col_out), 32'h0000_0007);
        repeat (4) @(negedge clk); chk("scan_wrap", 32'(kp.col_out), 32'h0000_000E);
        repeat (150) @(negedge clk);
        chk("idle_no_valid", 32'(n_rise), 32'h0);

        // Key 5, clean press and release.
        pressed[1*4+1] = 1'b1;
        wait_level(1'b1, LAT + 2, "k5_rise", n);
        chk("k5_latency_ok", 32'(n <= LAT), 32'h1);
        chk("k5_code", 32'(kp.key_code), 32'h5);
        repeat (100) @(negedge clk);
        chk("k5_held", 32'(kp.key_valid), 32'h1);
        pressed = '0;
        wait_level(1'b0, 60, "k5_fall", n);
        chk("k5_release_cycles", 32'(n), 32'd22);
        chk("k5_code_kept", 32'(kp.key_code), 32'h5);
        repeat (40) @(negedge clk);

        // Key # with contact bounce on press and release.
        r0 = n_rise; f0 = n_fall;
        for (int i = 0; i < 5; i++) begin
            pressed[3*4+2] = 1'b1; repeat (2) @(negedge clk);
            pressed[3*4+2] = 1'b0; repeat (2) @(negedge clk);
        end
        pressed[3*4+2] = 1'b1;
        wait_level(1'b1, LAT + 2, "hash_rise", n);
        repeat (60) @(negedge clk);
        chk("hash_code", 32'(kp.key_code), 32'hF);
        chk("hash_single_rise", 32'(n_rise - r0), 32'h1);
        for (int i = 0; i < 5; i++) begin
            pressed[3*4+2] = 1'b0; repeat (2) @(negedge clk);
            pressed[3*4+2] = 1'b1; repeat (2) @(negedge clk);
        end
        pressed = '0;
        wait_level(1'b0, 60, "hash_fall", n);
        repeat (40) @(negedge clk);
        chk("hash_single_fall", 32'(n_fall - f0), 32'h1);
        chk("hash_no_extra_rise", 32'(n_rise - r0), 32'h1);

        // Keys 1 and 4 together on column 0: ghost, nothing reported.
        r0 = n_rise;
        pressed[0*4+0] = 1'b1; pressed[1*4+0] = 1'b1;
        repeat (100) @(negedge clk);
        chk("ghost_no_rise", 32'(n_rise - r0), 32'h0);
        pressed[1*4+0] = 1'b0;
        wait_level(1'b1, LAT + 2, "ghost_then_1_rise", n);
        chk("ghost_then_1_code", 32'(kp.key_code), 32'h1);
        pressed = '0;
        wait_level(1'b0, 60, "key1_fall", n);
        repeat (40) @(negedge clk);

        // Reset while holding key 9.
        pressed[2*4+2] = 1'b1;
        wait_level(1'b1, LAT + 2, "k9_rise", n);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_key_valid", 32'(kp.key_valid), 32'h0);
        chk("midrst_key_code", 32'(kp.key_code), 32'h0);
        chk("midrst_col_out", 32'(kp.col_out), 32'h0000_000E);
        @(negedge clk);
        rst = 1'b0;
        wait_level(1'b1, LAT + 2, "k9_redetect", n);
        chk("k9_code", 32'(kp.key_code), 32'h9);
        pressed = '0;
        wait_level(1'b0, 60, "k9_fall", n);
        repeat (40) @(negedge clk);

        // Long hold of key 7: auto-repeat drops only when the feature is built.
        pressed[2*4+0] = 1'b1;
        wait_level(1'b1, LAT + 2, "k7_rise", n);
        drops = 0;
        for (int i = 1; i < 96; i++) begin
            @(negedge clk);
            if (!kp.key_valid) drops++;
        end
        chk("k7_repeat_drops", 32'(drops), 32'(EXP_DROPS_7));
        chk("k7_code", 32'(kp.key_code), 32'h7);
        pressed = '0;
        wait_level(1'b0, 60, "k7_fall", n);
        repeat (40) @(negedge clk);

        // Long hold of #: never repeats.
        pressed[3*4+2] = 1'b1;
        wait_level(1'b1, LAT + 2, "hash2_rise", n);
        drops = 0;
        for (int i = 1; i < 96; i++) begin
            @(negedge clk);
            if (!kp.key_valid) drops++;
        end
        chk("hash_repeat_drops", 32'(drops), 32'h0);
        pressed = '0;
        wait_level(1'b0, 60, "hash2_fall", n);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
